// File: rtl/i2c_uart_pkg.sv
// Shared types and constants for the I2C status UART reporter.
// Holds ASCII codes used in the report, the reporter FSM state enum
// and the UART transmitter bit-state enum.
package i2c_uart_pkg;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_1  = 8'h31;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_P  = 8'h50;
    localparam logic [7:0] CHAR_F  = 8'h46;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEND   = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } rep_state_t;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with valid/ready input handshake.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   data_i[8]      : character to send, taken on valid_i & ready_o
//   valid_i        : character available
//   ready_o        : high in idle and in the last cycle of a stop bit
//   tx_o           : serial line, idle high
module uart_tx
    import i2c_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic baud_last;
    logic accept;

    // Ready in the final stop-bit cycle lets the next start bit follow with no gap.
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign ready_o   = (state_q == U_IDLE) || ((state_q == U_STOP) && baud_last);
    assign accept    = valid_i && ready_o;
    assign tx_o      = tx_q;

    // Bit sequencing: start, 8 data LSB first, stop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            U_IDLE: begin
                if (accept) begin
                    state_d = U_START;
                    baud_d  = '0;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            U_START: begin
                if (baud_last) begin
                    state_d = U_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            U_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            U_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (accept) begin
                        state_d = U_START;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = U_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    // State register; reset drives the line high immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= U_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/i2c_status_uart_reporter.sv
// Snapshots the I2C per-transaction ack status on done_i and prints it as
// ASCII lines ("<bits>\r\n" per transaction, then "P\r\n" or "F\r\n") on a
// gapless UART 8N1 stream.
// Ports:
//   clk_i, rst_n_i  : clock, async active-low reset
//   done_i          : one-cycle pulse, status_i valid this cycle
//   status_i[NTRANS]: NBYTES ack bits per transaction
//   tx_o            : UART serial out
//   busy_o          : report in progress
//   report_done_o   : one-cycle pulse after the last stop bit
//   overrun_o       : sticky, done_i seen while busy
module i2c_status_uart_reporter
    import i2c_uart_pkg::*;
#(
    parameter int unsigned NBYTES       = 2,
    parameter int unsigned NTRANS       = 6,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              done_i,
    input  logic [NBYTES-1:0] status_i [NTRANS],
    output logic              tx_o,
    output logic              busy_o,
    output logic              report_done_o,
    output logic              overrun_o
);

    localparam int unsigned CW = $clog2(NBYTES + 2);
    localparam int unsigned TW = (NTRANS > 1) ? $clog2(NTRANS) : 1;

    rep_state_t        state_q, state_d;
    logic [TW-1:0]     trans_q, trans_d;
    logic [CW-1:0]     char_q, char_d;
    logic              summ_q, summ_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              rdone_q, rdone_d;
    logic              ovr_q, ovr_d;
    logic [NBYTES-1:0] snap_q [NTRANS];
    logic [NBYTES-1:0] snap_d [NTRANS];

    logic              uart_ready;
    logic [NBYTES-1:0] cur_word;
    logic              cur_bit;
    logic              all_ones;
    logic [7:0]        cur_char;

    // Character for the current (trans, char) position of the report.
    always_comb begin
        all_ones = 1'b1;
        cur_word = '0;
        cur_bit  = 1'b0;
        for (int t = 0; t < int'(NTRANS); t++) begin
            if (snap_q[t] != '1) all_ones = 1'b0;
            if (trans_q == TW'(t)) cur_word = snap_q[t];
        end
        // char 0 is the MSB of the status word
        for (int b = 0; b < int'(NBYTES); b++) begin
            if (char_q == CW'(int'(NBYTES) - 1 - b)) cur_bit = cur_word[b];
        end
        if (summ_q) begin
            case (char_q)
                CW'(0):  cur_char = all_ones ? CHAR_P : CHAR_F;
                CW'(1):  cur_char = CHAR_CR;
                default: cur_char = CHAR_LF;
            endcase
        end else if (char_q < CW'(NBYTES)) begin
            cur_char = cur_bit ? CHAR_1 : CHAR_0;
        end else if (char_q == CW'(NBYTES)) begin
            cur_char = CHAR_CR;
        end else begin
            cur_char = CHAR_LF;
        end
    end

    // Sequencer next-state and outputs.
    always_comb begin
        state_d = state_q;
        trans_d = trans_q;
        char_d  = char_q;
        summ_d  = summ_q;
        valid_d = valid_q;
        data_d  = data_q;
        busy_d  = busy_q;
        rdone_d = 1'b0;
        ovr_d   = ovr_q;
        snap_d  = snap_q;
        // The report_done cycle still counts as busy.
        if (done_i && (busy_q || rdone_q)) ovr_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (done_i && !rdone_q) begin
                    snap_d  = status_i;
                    busy_d  = 1'b1;
                    trans_d = '0;
                    char_d  = '0;
                    summ_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = cur_char;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (uart_ready) begin
                    valid_d = 1'b0;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                state_d = LOAD;
                if (summ_q) begin
                    if (char_q == CW'(2)) state_d = FINISH;
                    else                  char_d  = char_q + CW'(1);
                end else if (char_q == CW'(NBYTES + 1)) begin
                    char_d = '0;
                    if (trans_q == TW'(NTRANS - 1)) summ_d  = 1'b1;
                    else                            trans_d = trans_q + TW'(1);
                end else begin
                    char_d = char_q + CW'(1);
                end
            end
            FINISH: begin
                // Wait for the last stop bit's final cycle.
                if (uart_ready) begin
                    rdone_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            trans_q <= '0;
            char_q  <= '0;
            summ_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            rdone_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int t = 0; t < int'(NTRANS); t++) snap_q[t] <= '0;
        end else begin
            state_q <= state_d;
            trans_q <= trans_d;
            char_q  <= char_d;
            summ_q  <= summ_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            rdone_q <= rdone_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_q),
        .valid_i (valid_q),
        .ready_o (uart_ready),
        .tx_o    (tx_o)
    );

    assign busy_o        = busy_q;
    assign report_done_o = rdone_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_i2c_status_uart_reporter.sv
// Directed bench: decodes the UART stream of two reporter instances
// (2x6 and 1x1 status, 4 clocks per bit) and checks text, timing and flags.
module tb_i2c_status_uart_reporter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done0, done1;
    logic [1:0] st0 [6];
    logic [0:0] st1 [1];
    logic       tx0, busy0, rdone0, ovr0;
    logic       tx1, busy1, rdone1, ovr1;
    logic       sel;
    logic       m_tx, m_busy, m_rdone, m_ovr;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] rx_q [$];
    int         st_q [$];
    int         cell_err = 0;

    i2c_status_uart_reporter #(.NBYTES(2), .NTRANS(6), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .done_i(done0), .status_i(st0),
        .tx_o(tx0), .busy_o(busy0), .report_done_o(rdone0), .overrun_o(ovr0)
    );

    i2c_status_uart_reporter #(.NBYTES(1), .NTRANS(1), .CLKS_PER_BIT(CPB)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .done_i(done1), .status_i(st1),
        .tx_o(tx1), .busy_o(busy1), .report_done_o(rdone1), .overrun_o(ovr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign m_tx    = sel ? tx1    : tx0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_rdone = sel ? rdone1 : rdone0;
    assign m_ovr   = sel ? ovr1   : ovr0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_done(input logic v);
        if (sel) done1 = v;
        else     done0 = v;
    endtask

    // UART decoder: samples every falling clock edge, one frame = 10*CPB samples.
    initial begin : monitor
        logic [10*CPB-1:0] smp;
        logic [7:0]        ch;
        int                s0;
        forever begin
            @(negedge clk);
            if (m_tx === 1'b0) begin
                s0     = cyc;
                smp    = '0;
                for (int k = 1; k < 10 * CPB; k++) begin
                    @(negedge clk);
                    smp[k] = m_tx;
                end
                for (int j = 0; j < 10; j++)
                    for (int k = 0; k < CPB; k++)
                        if (smp[j*CPB+k] !== smp[j*CPB+1]) cell_err++;
                if (smp[10*CPB-1] !== 1'b1) cell_err++;
                for (int j = 0; j < 8; j++) ch[j] = smp[(j+1)*CPB+1];
                rx_q.push_back(ch);
                st_q.push_back(s0);
            end
        end
    end

    // mode: 0 plain, 1 second done_i 100 cycles in, 2 done_i in the report_done cycle
    task automatic run_report(input string name, input string exp, input int exp_lat, input int mode);
        int t_done;
        int lat;
        int gaps;
        logic got;
        rx_q.delete();
        st_q.delete();
        cell_err = 0;
        got = 1'b0;
        lat = -1;
        set_done(1'b1);
        @(negedge clk);
        t_done = cyc;
        set_done(1'b0);
        check({name, "_busy_rise"}, int'(m_busy), 1);
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge clk);
            set_done(1'b0);
            if (mode == 1 && cyc - t_done == 100) begin
                st0 = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
                set_done(1'b1);
            end
            if (m_rdone === 1'b1) begin
                got = 1'b1;
                lat = cyc - t_done;
            end
        end
        check({name, "_done_latency"}, lat, exp_lat);
        if (mode == 2) set_done(1'b1);
        @(negedge clk);
        set_done(1'b0);
        check({name, "_done_pulse_end"}, int'(m_rdone), 0);
        check({name, "_busy_fall"}, int'(m_busy), 0);
        check({name, "_first_start"}, (st_q.size() > 0) ? st_q[0] - t_done : -1, 2);
        check({name, "_nchars"}, rx_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            check($sformatf("%s_char%0d", name, i),
                  (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(exp[i]));
        gaps = 0;
        for (int i = 1; i < st_q.size(); i++)
            if (st_q[i] - st_q[i-1] != 10 * CPB) gaps++;
        check({name, "_gaps"}, gaps, 0);
        check({name, "_cells"}, cell_err, 0);
    endtask

    initial begin : stim
        int lows;
        int pulses;
        rst_n = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        sel   = 1'b0;
        st0   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        st1   = '{1'b0};
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx0), 1);
        rst_n = 1'b1;

        // Idle after reset: line stays high, no report activity.
        lows = 0;
        pulses = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1) lows++;
            if (rdone0 !== 1'b0 || rdone1 !== 1'b0) pulses++;
        end
        check("idle_tx", lows, 0);
        check("idle_rdone", pulses, 0);
        check("idle_busy", int'(busy0), 0);
        check("idle_ovr", int'(ovr0), 0);

        st0 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        run_report("all_ack", "11\015\n11\015\n11\015\n11\015\n11\015\n11\015\nP\015\n", 1082, 0);
        repeat (5) @(negedge clk);

        st0 = '{2'd3, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3};
        run_report("mixed", "11\015\n10\015\n11\015\n01\015\n00\015\n11\015\nF\015\n", 1082, 0);
        check("mixed_ovr", int'(ovr0), 0);
        repeat (5) @(negedge clk);

        st0 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        run_report("overrun", "11\015\n11\015\n11\015\n11\015\n11\015\n11\015\nP\015\n", 1082, 1);
        check("overrun_set", int'(ovr0), 1);
        repeat (200) @(negedge clk);
        check("overrun_sticky", int'(ovr0), 1);
        check("overrun_no_restart", int'(busy0), 0);

        // Reset in the middle of data bit 0 of a '0' character.
        st0 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        done0 = 1'b1;
        @(negedge clk);
        done0 = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_tx", int'(tx0), 0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", int'(tx0), 1);
        check("async_rst_busy", int'(busy0), 0);
        check("async_rst_ovr", int'(ovr0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        st0 = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3};
        run_report("after_rst", "01\015\n00\015\n10\015\n11\015\n11\015\n11\015\nF\015\n", 1082, 0);
        repeat (5) @(negedge clk);

        // Single-transaction, single-byte instance; done_i lands on report_done.
        sel = 1'b1;
        st1 = '{1'b1};
        run_report("tiny", "1\015\nP\015\n", 242, 2);
        check("tiny_ovr", int'(ovr1), 1);
        repeat (50) @(negedge clk);
        check("tiny_ignored", rx_q.size(), 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_status_uart_reporter.md
Name: i2c_status_uart_reporter

Overview:
- Downstream consumer of the I2C transaction engine's per-transaction status array and done pulse.
- On each done pulse, snapshots all status words and serialises a human-readable ASCII report over a UART 8N1 transmit line, e.g. to a host terminal on the Nexys7 USB-UART.
- Contains the character sequencer plus one UART transmitter sub-module.

Parameters:
- NBYTES, 2, status bits per transaction (one per byte; 1 = byte acknowledged).
- NTRANS, 6, number of transactions in the status array.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset.
- done_i  input  1  single-cycle pulse: I2C sequence finished, status_i valid this cycle.
- status_i  input  [NBYTES-1:0] x NTRANS (unpacked [NTRANS])  per-transaction ack bits.
- tx_o  output  1  UART serial out, idle high.
- busy_o  output  1  report in progress.
- report_done_o  output  1  one-cycle pulse after the last stop bit of a report.
- overrun_o  output  1  sticky: done_i arrived while busy_o was high.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: tx_o=1, busy_o=0, report_done_o=0, overrun_o=0, snapshot=0, FSM=IDLE.
- Reset mid-character: tx_o returns high asynchronously, and the partial frame is abandoned.
- Report format, per transaction t = 0..NTRANS-1:
  - NBYTES chars, status_i[t] MSB first; bit 1 → '1' (0x31), bit 0 → '0' (0x30).
  - Then CR (0x0D) and LF (0x0A).
- Report summary line: 'P' (0x50) if every snapshot bit is 1, else 'F' (0x46); then CR LF.
- Total characters = NTRANS*(NBYTES+2)+3; default 27.
- UART frame:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit held exactly CLKS_PER_BIT cycles.
  - Characters are back-to-back with zero idle cycles: the next start bit begins on the cycle after the previous stop bit's last cycle.
- FSM states: IDLE → LOAD → SEND → (NEXT → LOAD | FINISH) → IDLE.
  - IDLE: done_i=1 captures status_i into the snapshot, then → LOAD.
  - LOAD: computes the current char from trans_idx/char_idx and asserts valid to the UART.
  - SEND: waits for UART accept.
  - NEXT: advances char_idx (0..NBYTES+1) and trans_idx, then the summary index.
  - FINISH: pulses report_done_o, clears busy_o.
- Handshake with uart_tx: valid/ready.
  - uart_tx ready is high in idle and during the final cycle of a stop bit.
  - Accept occurs on a valid&ready edge.
  - The sequencer must present the next char early enough to keep frames gapless; the char index is precomputed during SEND.
- Latency:
  - done_i high at edge N → busy_o=1 after edge N and tx_o falls after edge N+2.
  - report_done_o pulses one cycle after the final stop bit ends.
  - busy_o falls with the report_done_o pulse.
- done_i while busy_o=1: ignored (snapshot unchanged) and overrun_o set; only reset clears overrun_o.
- done_i in the same cycle as report_done_o: treated as busy, so it is ignored and sets overrun_o.
- status_i changes after capture have no effect on the report in progress.
- Index counters use $clog2 widths, with a minimum width of 1 when NBYTES or NTRANS is 1.

Decomposition:
- Package i2c_uart_pkg holds:
  - ASCII constants (CHAR_0, CHAR_1, CHAR_CR, CHAR_LF, CHAR_P, CHAR_F).
  - Reporter state enum rep_state_t {IDLE, LOAD, SEND, NEXT, FINISH}.
  - UART bit-state enum.
- Sub-module uart_tx (params CLKS_PER_BIT; ports clk_i, rst_n_i, data_i[8], valid_i, ready_o, tx_o) handles the baud counter, bit counter and shift register.

Test Plan:
- Reset with CLKS_PER_BIT=4, sim 1000 cycles with no done_i → tx_o=1, busy_o=0, report_done_o never pulses.
- done_i with status {3,3,3,3,3,3} → UART decoder reads "11\r\n" x6 then "P\r\n". tx_o first falls 2 cycles after done_i. report_done_o pulses exactly 27*10*4+2 cycles after done_i, with no gaps between frames.
- status {3,2,3,1,0,3} → lines "11","10","11","01","00","11", summary 'F'; each bit cell measures exactly 4 cycles.
- Second done_i 100 cycles into a report, with different status → report content unchanged, overrun_o=1 and stays 1 until reset.
- Assert rst_n_i low mid-data-bit → tx_o=1 within the same cycle (async), busy_o=0. A new done_i after release yields a complete, correct report.
- NBYTES=1, NTRANS=1, status {1} → "1\r\nP\r\n" (6 chars), report_done_o after 6*10*CLKS_PER_BIT+2 cycles.
